// File: rtl/cpu_exc_pkg.sv
// Shared types and constants for the precise-trap sequencer.
package cpu_exc_pkg;

  typedef enum logic [4:0] {
    INT  = 5'd0,
    ADEL = 5'd4,
    ADES = 5'd5,
    SYS  = 5'd8,
    BP   = 5'd9,
    RI   = 5'd10,
    OV   = 5'd12
  } exc_code_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRAP  = 3'd1,
    ERET  = 3'd2,
    FLUSH = 3'd3,
    REDIR = 3'd4
  } exc_state_t;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  function automatic logic is_addr_code(input exc_code_t code);
    return (code == ADEL) || (code == ADES);
  endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// Commit-stage, CP0 exception-port and fetch-redirect bundle of the trap sequencer.
interface exception_ctrl_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        commit_eret;
  logic        exc_if_adel;
  logic        exc_ri;
  logic        exc_sys;
  logic        exc_bp;
  logic        exc_ov;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] data_vaddr;
  logic [5:0]  hw_int;
  logic [1:0]  sw_int;
  logic        allow_interrupt;
  logic [7:0]  interrupt_mask;
  logic [31:0] epc_address;
  logic        exp_en;
  logic        exp_badvaddr_en;
  logic [31:0] exp_badvaddr;
  logic        exp_bd;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        eret_clr;
  logic [7:0]  int_pending;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  modport master (
    output commit_valid, commit_pc, commit_bd, commit_eret,
    output exc_if_adel, exc_ri, exc_sys, exc_bp, exc_ov, exc_adel, exc_ades, data_vaddr,
    output hw_int, sw_int, allow_interrupt, interrupt_mask, epc_address, redirect_ready,
    input  commit_ready, exp_en, exp_badvaddr_en, exp_badvaddr, exp_bd, exp_code, exp_epc,
    input  eret_clr, int_pending, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, commit_bd, commit_eret,
    input  exc_if_adel, exc_ri, exc_sys, exc_bp, exc_ov, exc_adel, exc_ades, data_vaddr,
    input  hw_int, sw_int, allow_interrupt, interrupt_mask, epc_address, redirect_ready,
    output commit_ready, exp_en, exp_badvaddr_en, exp_badvaddr, exp_bd, exp_code, exp_epc,
    output eret_clr, int_pending, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/int_sync.sv
// Multi-stage flop synchroniser for asynchronous interrupt lines.
module int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain_r [STAGES];

  // Shift chain; stage 0 is the only one that may go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain_r[i] <= {WIDTH{1'b0}};
    end else begin
      chain_r[0] <= din;
      for (int i = 1; i < STAGES; i++) chain_r[i] <= chain_r[i-1];
    end
  end

  assign dout = chain_r[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// Precise-trap sequencer: cause priority, CP0 exception write, pipeline flush and fetch redirect.
module exception_ctrl
  import cpu_exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input logic             clk,
  input logic             rst,
  exception_ctrl_if.slave bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  exc_state_t  state_r, state_next_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic [5:0]  hw_sync_s;
  logic [7:0]  int_pending_s;
  logic        int_req_s;
  logic        cause_valid_s;
  logic        cause_fetch_s;
  exc_code_t   cause_code_s;
  logic        accept_s;
  exc_code_t   code_r;
  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic        badvaddr_en_r;
  logic        bd_r;
  logic [31:0] target_r;

  int_sync #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_int_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.hw_int),
    .dout (hw_sync_s)
  );

  assign int_pending_s = {hw_sync_s, bus.sw_int};
  assign int_req_s     = bus.allow_interrupt & (|(int_pending_s & bus.interrupt_mask));

  // Fixed-priority cause encoder.
  always_comb begin
    cause_valid_s = 1'b1;
    cause_fetch_s = 1'b0;
    cause_code_s  = INT;
    if (int_req_s) begin
      cause_code_s = INT;
    end else if (bus.exc_if_adel) begin
      cause_code_s  = ADEL;
      cause_fetch_s = 1'b1;
    end else if (bus.exc_ri) begin
      cause_code_s = RI;
    end else if (bus.exc_sys) begin
      cause_code_s = SYS;
    end else if (bus.exc_bp) begin
      cause_code_s = BP;
    end else if (bus.exc_ov) begin
      cause_code_s = OV;
    end else if (bus.exc_adel) begin
      cause_code_s = ADEL;
    end else if (bus.exc_ades) begin
      cause_code_s = ADES;
    end else begin
      cause_valid_s = 1'b0;
    end
  end

  assign accept_s = (state_r == IDLE) & bus.commit_valid & (cause_valid_s | bus.commit_eret);

  // Next-state and flush counter; the counter spans TRAP/ERET plus FLUSH.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (bus.commit_valid && cause_valid_s) begin
          state_next_s = TRAP;
          cnt_next_s   = FLUSH_LOAD;
        end else if (bus.commit_valid && bus.commit_eret) begin
          state_next_s = ERET;
          cnt_next_s   = FLUSH_LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      TRAP, ERET, FLUSH: begin
        if (cnt_r == 4'd0) begin
          state_next_s = REDIR;
        end else begin
          state_next_s = FLUSH;
          cnt_next_s   = cnt_r - 4'd1;
        end
      end
      REDIR: begin
        if (bus.redirect_ready) state_next_s = IDLE;
        else                    state_next_s = REDIR;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Capture CP0 payload and redirect target on the accepted commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_r        <= INT;
      epc_r         <= 32'd0;
      badvaddr_r    <= 32'd0;
      badvaddr_en_r <= 1'b0;
      bd_r          <= 1'b0;
      target_r      <= 32'd0;
    end else if (accept_s) begin
      code_r        <= cause_code_s;
      epc_r         <= bus.commit_bd ? (bus.commit_pc - 32'd4) : bus.commit_pc;
      badvaddr_r    <= cause_fetch_s ? bus.commit_pc : bus.data_vaddr;
      badvaddr_en_r <= is_addr_code(cause_code_s);
      bd_r          <= bus.commit_bd;
      target_r      <= cause_valid_s ? EXC_VECTOR : bus.epc_address;
    end
  end

  assign bus.commit_ready    = (state_r == IDLE);
  assign bus.exp_en          = (state_r == TRAP);
  assign bus.exp_code        = bus.exp_en ? code_r : 5'd0;
  assign bus.exp_epc         = bus.exp_en ? epc_r : 32'd0;
  assign bus.exp_bd          = bus.exp_en & bd_r;
  assign bus.exp_badvaddr_en = bus.exp_en & badvaddr_en_r;
  assign bus.exp_badvaddr    = bus.exp_en ? badvaddr_r : 32'd0;
  assign bus.eret_clr        = (state_r == ERET);
  assign bus.flush           = (state_r == TRAP) | (state_r == ERET) | (state_r == FLUSH);
  assign bus.redirect_valid  = (state_r == REDIR);
  assign bus.redirect_pc     = bus.redirect_valid ? target_r : 32'd0;
  assign bus.int_pending     = int_pending_s;

endmodule
